alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
//  Parametrised multi-cycle ALU for the execute stage. It extends the 2-bit add/sub/and/or ALU:
//  - width is set by parameter;
//  - adds EOR, MOV and an iterative shift-add multiply;
//  - outputs are registered behind a start/busy/done handshake.
//  The hazard unit stalls the pipeline on busy and captures Result/Flags when done pulses.
// PARAMETERS
//  WIDTH   32  operand/result width in bits (>=4)
//  MUL_EN  1   1: MUL implemented; 0: MUL opcode treated as reserved
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  reset       in   1      asynchronous, active-low reset (0 = reset asserted)
//  start       in   1      request; accepted only when busy=0
//  ALUControl  in   3      op: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110 MOV, 111 reserved
//  a           in   WIDTH  operand A (sampled at accept only)
//  b           in   WIDTH  operand B (sampled at accept only)
//  Result      out  WIDTH  registered result; holds until the next completed op
//  Flags       out  4      registered {N,Z,C,V}; updated together with Result
//  busy        out  1      high while a MUL is in progress
//  done        out  1      one-cycle pulse: Result/Flags updated this cycle
// BEHAVIOUR
//  Reset:
//  - reset=0 forces Result=0, Flags=0, busy=0, done=0, state IDLE, multiplier regs=0.
//  - Takes effect immediately, without waiting for a clock edge.
//  - Reset mid-MUL aborts the op; no done pulse is produced for it.
//  States: IDLE, MUL.
//  Accept:
//  - Occurs on a rising edge with state IDLE and start=1.
//  - a, b and ALUControl are latched; later input changes have no effect.
//  Single-cycle ops (ADD/SUB/AND/ORR/EOR/MOV/reserved):
//  - Result/Flags load at the accept edge; done=1 for the following cycle; busy stays 0.
//  - Latency is 1.
//  MUL (MUL_EN=1):
//  - Accept edge T0: busy=1, state MUL, acc=0, mcand=a, mplier=b, cnt=0.
//  - Edges T1..T_WIDTH: if mplier[0], acc+=mcand; mcand<<=1; mplier>>=1; cnt++.
//  - All arithmetic is modulo 2^WIDTH.
//  - At edge T_WIDTH: Result=low WIDTH bits of product; busy->0; done=1 for one cycle; state IDLE.
//  - Latency is WIDTH cycles. busy is high for exactly WIDTH cycles.
//  Handshake rules:
//  - start while busy=1 is ignored and is not queued.
//  - start during the done cycle is accepted (state is already IDLE), so back-to-back ops need no bubble.
//  - done never pulses without a preceding accept.
//  - Result and Flags do not change except on a done cycle or reset.
//  Arithmetic (sum computed WIDTH+1 bits wide):
//  - ADD: sum = a+b. C = carry-out. V = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]).
//  - SUB: sum = a+~b+1. C = carry-out, i.e. 1 when a>=b unsigned. V = (a[MSB]!=b[MSB]) & (sum[MSB]!=a[MSB]).
//  - AND/ORR/EOR: bitwise. MOV: Result=b. MUL: low product.
//  - C=0 and V=0 for all non-add/sub ops.
//  - N = Result[MSB] and Z = (Result==0) for every op.
//  - Reserved 111, or 101 with MUL_EN=0: Result=0, Flags=0100, latency 1.
// TESTING (WIDTH=32)
//  1. ADD a=7FFFFFFF b=00000001 -> Result=80000000, Flags=1001, done 1 cycle after accept, busy never high.
//  2. SUB a=b=5 -> 00000000/0110. Then SUB a=3 b=5 -> FFFFFFFE/1000. Then SUB a=80000000 b=1 -> 7FFFFFFF/0011.
//  3. MUL a=0000FFFF b=00010001 -> FFFFFFFF/1000. busy high exactly 32 cycles, done on cycle 32. a/b toggled mid-op have no effect.
//  4. ADD start asserted during MUL -> ignored, no extra done. ADD 2+3 started on the MUL done cycle -> 00000005/0000 one cycle later.
//  5. reset=0 mid-MUL at iteration 10, between edges -> Result/Flags/busy/done=0 immediately. After release, MUL 7*6 -> 0000002A after 32 cycles.
//  6. a=F0F0F0F0 b=0FF00FF0: AND->00F000F0/0000, ORR->FFF0FFF0/1000, EOR->FF00FF00/1000, MOV->0FF00FF0/0000, op 111->00000000/0100.

Source files
------------

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: single-cycle add/sub/logic/mov plus an iterative
// shift-add multiply, all results registered behind a start/busy/done handshake.
module alu_mc #(
    parameter int unsigned Width = 32,
    parameter bit          MulEn = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [2:0]       alu_control_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    output logic [Width-1:0] result_o,
    output logic [3:0]       flags_o,
    output logic             busy_o,
    output logic             done_o
);

    localparam int unsigned Msb  = Width - 1;
    localparam int unsigned CntW = $clog2(Width);
    localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

    localparam logic [2:0] OpAdd = 3'b000;
    localparam logic [2:0] OpSub = 3'b001;
    localparam logic [2:0] OpAnd = 3'b010;
    localparam logic [2:0] OpOrr = 3'b011;
    localparam logic [2:0] OpEor = 3'b100;
    localparam logic [2:0] OpMul = 3'b101;
    localparam logic [2:0] OpMov = 3'b110;

    typedef enum logic [0:0] {StIdle, StMul} state_e;

    state_e            state_q, state_d;
    logic [Width-1:0]  result_q, result_d;
    logic [3:0]        flags_q, flags_d;
    logic              done_q, done_d;
    logic [Width-1:0]  acc_q, acc_d;
    logic [Width-1:0]  mcand_q, mcand_d;
    logic [Width-1:0]  mplier_q, mplier_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    logic [Width:0]    sum;
    logic [Width-1:0]  alu_res;
    logic              alu_c;
    logic              alu_v;
    logic [3:0]        alu_flags;
    logic [Width-1:0]  acc_sum;
    logic              is_mul;

    assign is_mul = MulEn && (alu_control_i == OpMul);

    // Single-cycle datapath; MUL without MulEn and 111 fall to the reserved default.
    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (alu_control_i)
            OpAdd: begin
                sum     = {1'b0, a_i} + {1'b0, b_i};
                alu_res = sum[Width-1:0];
                alu_c   = sum[Width];
                alu_v   = (a_i[Msb] == b_i[Msb]) && (sum[Msb] != a_i[Msb]);
            end
            OpSub: begin
                sum     = {1'b0, a_i} + {1'b0, ~b_i} + {{Width{1'b0}}, 1'b1};
                alu_res = sum[Width-1:0];
                alu_c   = sum[Width];
                alu_v   = (a_i[Msb] != b_i[Msb]) && (sum[Msb] != a_i[Msb]);
            end
            OpAnd:   alu_res = a_i & b_i;
            OpOrr:   alu_res = a_i | b_i;
            OpEor:   alu_res = a_i ^ b_i;
            OpMov:   alu_res = b_i;
            default: alu_res = '0;
        endcase
        alu_flags = {alu_res[Msb], alu_res == '0, alu_c, alu_v};
    end

    assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (is_mul) begin
                        state_d  = StMul;
                        acc_d    = '0;
                        mcand_d  = a_i;
                        mplier_d = b_i;
                        cnt_d    = '0;
                    end else begin
                        result_d = alu_res;
                        flags_d  = alu_flags;
                        done_d   = 1'b1;
                    end
                end
            end
            StMul: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                // The last iteration's sum goes straight to Result, no extra cycle.
                if (cnt_q == CntLast) begin
                    state_d  = StIdle;
                    result_d = acc_sum;
                    flags_d  = {acc_sum[Msb], acc_sum == '0, 2'b00};
                    done_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign result_o = result_q;
    assign flags_o  = flags_q;
    assign busy_o   = (state_q == StMul);
    assign done_o   = done_q;

endmodule
